fp16_sum_ctrl: RTL and testbench

Sequencer that reduces a vector of NUM_INPUTS IEEE-754 half-precision values to one sum by time-multiplexing a single external two-input FP16 adder. It sits between the layer's weighted-product stream and the activation stage. It buffers one vector, tracks the vector's largest exponent, issues the accumulation adds in order, and presents the sum with a valid/ready handshake.

---
 rtl/fp16_pkg.sv | 30 +++
 rtl/fp16_sum_ctrl.sv | 139 +++++++++++++
 tb/tb_fp16_sum_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp16_pkg                                               |
// | Description : Shared FP16 field positions, word type and the state   |
// |               set of the summation sequencer.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fp16_pkg;

    localparam int FP16_SIGN   = 15;
    localparam int FP16_EXP_HI = 14;
    localparam int FP16_EXP_LO = 10;
    localparam int FP16_FRAC_W = 10;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sum_state_t;

    // Raw biased exponent field of a half-precision word.
    function automatic logic [4:0] fp16_expo(input fp16_t v);
        return v[FP16_EXP_HI:FP16_EXP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_sum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp16_sum_ctrl                                          |
// | Description : Buffers one vector of FP16 words, tracks its largest   |
// |               exponent and reduces it through one shared external   |
// |               two-input FP16 adder in the fixed order               |
// |               ((w0+w1)+w2)+...  The sum leaves on a valid/ready port.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp16_sum_ctrl
    import fp16_pkg::*;
#(
    parameter int NUM_INPUTS = 8,
    parameter int ADD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        add_valid,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [4:0]  out_max_expo
);

    localparam int c_CNT_W = $clog2(NUM_INPUTS + 1);
    localparam int c_TMR_W = $clog2(ADD_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(NUM_INPUTS - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LD  = c_TMR_W'(ADD_LAT - 1);

    sum_state_t           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_idx;
    logic [c_TMR_W-1:0]   r_timer;
    fp16_t                r_acc;
    logic [4:0]           r_max_expo;
    fp16_t                r_buf [NUM_INPUTS];

    logic [4:0]           w_in_expo;
    logic                 w_take;
    fp16_t                w_buf_sel;

    assign w_in_expo = fp16_expo(in_data);
    assign w_take    = (r_state == LOAD) && in_valid;

    // Vector storage; contents are only meaningful below r_cnt, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rst_n && !clear && w_take && (r_cnt == c_CNT_W'(i))) begin
                r_buf[i] <= in_data;
            end
        end
    end

    // Operand B selection by the running add index (explicit mux keeps the
    // index width independent of the array depth).
    always_comb begin
        w_buf_sel = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_idx == c_CNT_W'(i)) begin
                w_buf_sel = r_buf[i];
            end
        end
    end

    // Sequencer: load the vector, then issue/await one add per remaining word.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state    <= LOAD;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_acc      <= '0;
            r_max_expo <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == '0) begin
                            // First word seeds both the accumulator and the max.
                            r_acc      <= in_data;
                            r_max_expo <= w_in_expo;
                        end else if (w_in_expo > r_max_expo) begin
                            r_max_expo <= w_in_expo;
                        end
                        if (r_cnt == c_LAST) begin
                            r_idx   <= c_CNT_W'(1);
                            r_state <= (NUM_INPUTS == 1) ? DONE : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_timer <= c_TMR_LD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Timer reaches zero in the cycle the adder result is valid.
                    if (r_timer == '0) begin
                        r_acc   <= add_res;
                        r_idx   <= r_idx + c_CNT_W'(1);
                        r_state <= (r_idx == c_LAST) ? DONE : ISSUE;
                    end else begin
                        r_timer <= r_timer - c_TMR_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state    <= LOAD;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_max_expo <= '0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Outputs decoded from registered state only; idle fields are forced to 0.
    always_comb begin
        in_ready     = (r_state == LOAD);
        add_valid    = (r_state == ISSUE);
        add_a        = (r_state == ISSUE) ? r_acc     : 16'h0000;
        add_b        = (r_state == ISSUE) ? w_buf_sel : 16'h0000;
        out_valid    = (r_state == DONE);
        out_data     = (r_state == DONE) ? r_acc      : 16'h0000;
        out_max_expo = (r_state == DONE) ? r_max_expo : 5'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_sum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fp16_sum_ctrl                                       |
// | Description : Bench for fp16_sum_ctrl: three instances (4x2, 1x2,    |
// |               3x1), behavioural FP16 adders, a time-based reference  |
// |               model for the 4-input instance and directed vectors.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fp16_sum_ctrl;

    localparam int c_NA = 4;
    localparam int c_LA = 2;

    logic clk = 1'b0;
    logic rst_n, clear;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_acc;

    // ---------------- instance A: NUM_INPUTS=4, ADD_LAT=2 ----------------
    logic        a_in_valid, a_in_ready, a_add_valid, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_add_a, a_add_b, a_add_res, a_out_data;
    logic [4:0]  a_out_max_expo;

    fp16_sum_ctrl #(.NUM_INPUTS(c_NA), .ADD_LAT(c_LA)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .add_valid(a_add_valid), .add_a(a_add_a), .add_b(a_add_b), .add_res(a_add_res),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_max_expo(a_out_max_expo));

    // ---------------- instance B: NUM_INPUTS=1, ADD_LAT=2 ----------------
    logic        b_in_valid, b_in_ready, b_add_valid, b_out_valid, b_out_ready;
    logic [15:0] b_in_data, b_add_a, b_add_b, b_out_data;
    logic [15:0] b_add_res = 16'h0000;
    logic [4:0]  b_out_max_expo;

    fp16_sum_ctrl #(.NUM_INPUTS(1), .ADD_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .add_valid(b_add_valid), .add_a(b_add_a), .add_b(b_add_b), .add_res(b_add_res),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_max_expo(b_out_max_expo));

    // ---------------- instance C: NUM_INPUTS=3, ADD_LAT=1 ----------------
    logic        c_in_valid, c_in_ready, c_add_valid, c_out_valid, c_out_ready;
    logic [15:0] c_in_data, c_add_a, c_add_b, c_add_res, c_out_data;
    logic [4:0]  c_out_max_expo;

    fp16_sum_ctrl #(.NUM_INPUTS(3), .ADD_LAT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .add_valid(c_add_valid), .add_a(c_add_a), .add_b(c_add_b), .add_res(c_add_res),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_max_expo(c_out_max_expo));

    // ---------------- behavioural FP16 arithmetic ----------------
    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        m = real'(int'(h[9:0])) / 1024.0;
        if (e == 0) e = 1; else m = m + 1.0;
        while (e > 15) begin m = m * 2.0; e--; end
        while (e < 15) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  a;
        int   e, f;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        if (a < 1.0) begin
            f = $rtoi(a * 1024.0 + 0.5);
            e = 0;
        end else begin
            f = $rtoi((a - 1.0) * 1024.0 + 0.5);
            if (f == 1024) begin f = 0; e++; end
        end
        if (e > 30) return {s, 15'h7C00};
        return {s, 5'(e), 10'(f)};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
        return r2h(h2r(x) + h2r(y));
    endfunction

    // Reference adders with the instance latencies.
    logic [15:0] a_pipe0, a_pipe1, c_pipe0;
    always @(posedge clk) begin
        a_pipe0 <= a_add_valid ? fp_add(a_add_a, a_add_b) : 16'h0000;
        a_pipe1 <= a_pipe0;
        c_pipe0 <= c_add_valid ? fp_add(c_add_a, c_add_b) : 16'h0000;
    end
    assign a_add_res = a_pipe1;
    assign c_add_res = c_pipe0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    logic [15:0] m_w    [c_NA];
    logic [15:0] m_part [c_NA];
    logic [15:0] m_sum;
    logic [4:0]  m_maxe;
    int          m_n = 0, m_t = 0, m_done = 0;
    bit          m_busy = 0, m_init = 0;

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_busy = 0; m_n = 0; m_init = 1;
        end else if (!m_busy) begin
            if (a_in_valid) begin
                m_w[m_n] = a_in_data;
                m_n++;
                if (m_n == c_NA) begin
                    m_busy  = 1;
                    m_t     = cyc;
                    m_done  = cyc + 1 + (c_NA - 1) * (c_LA + 1);
                    m_part[0] = m_w[0];
                    m_maxe    = m_w[0][14:10];
                    for (int k = 1; k < c_NA; k++) begin
                        m_part[k] = fp_add(m_part[k-1], m_w[k]);
                        if (m_w[k][14:10] > m_maxe) m_maxe = m_w[k][14:10];
                    end
                    m_sum = m_part[c_NA-1];
                end
            end
        end else if (cyc >= m_done && a_out_ready) begin
            m_busy = 0; m_n = 0;
        end
        cyc++;
    end

    // Per-cycle compare of every A output against the model.
    always @(negedge clk) begin
        if (m_init) begin
            bit ov, av;
            int k;
            ov = m_busy && (cyc >= m_done);
            av = m_busy && (cyc < m_done) && (((cyc - m_t - 1) % (c_LA + 1)) == 0);
            k  = (cyc - m_t - 1) / (c_LA + 1);
            chk("a_in_ready",  {31'd0, a_in_ready},  {31'd0, !m_busy});
            chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, ov});
            chk("a_add_valid", {31'd0, a_add_valid}, {31'd0, av});
            chk("a_add_a", {16'd0, a_add_a}, av ? {16'd0, m_part[k]} : 32'd0);
            chk("a_add_b", {16'd0, a_add_b}, av ? {16'd0, m_w[k+1]}  : 32'd0);
            chk("a_out_data", {16'd0, a_out_data}, ov ? {16'd0, m_sum} : 32'd0);
            chk("a_out_max_expo", {27'd0, a_out_max_expo}, ov ? {27'd0, m_maxe} : 32'd0);
        end
    end

    // Issue-strobe monitors for B and C.
    int b_pulses = 0;
    int c_pulses = 0;
    int c_pcyc [4];
    always @(negedge clk) begin
        if (b_add_valid) b_pulses++;
        if (c_add_valid) begin
            if (c_pulses < 4) c_pcyc[c_pulses] = cyc;
            c_pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_in(input int which, input logic v, input logic [15:0] d);
        case (which)
            0: begin a_in_valid = v; a_in_data = d; end
            1: begin b_in_valid = v; b_in_data = d; end
            default: begin c_in_valid = v; c_in_data = d; end
        endcase
    endtask

    task automatic send(input int which, input logic [15:0] w, input int gap);
        bit ok;
        int tries;
        for (int g = 0; g < gap; g++) begin
            drive_in(which, 1'b0, 16'h0000);
            @(posedge clk); #1;
        end
        drive_in(which, 1'b1, w);
        tries = 0;
        ok    = 0;
        while (!ok && tries < 60) begin
            @(negedge clk);
            ok = (which == 0) ? a_in_ready : (which == 1) ? b_in_ready : c_in_ready;
            if (ok) last_acc = cyc;
            @(posedge clk); #1;
            tries++;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        drive_in(which, 1'b0, 16'h0000);
    endtask

    task automatic set_ordy(input int which, input logic v);
        case (which)
            0: a_out_ready = v;
            1: b_out_ready = v;
            default: c_out_ready = v;
        endcase
    endtask

    task automatic wait_out(input int which, input int lat, input logic [15:0] d,
                            input logic [4:0] me, input int stall);
        bit   ov;
        int   tries;
        logic [15:0] od;
        logic [4:0]  om;
        tries = 0;
        ov    = 0;
        while (!ov && tries < 80) begin
            @(negedge clk);
            ov = (which == 0) ? a_out_valid : (which == 1) ? b_out_valid : c_out_valid;
            tries++;
        end
        if (!ov) begin
            chk("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc - last_acc, lat);
            for (int s = 0; s < stall; s++) @(negedge clk);
            od = (which == 0) ? a_out_data : (which == 1) ? b_out_data : c_out_data;
            om = (which == 0) ? a_out_max_expo : (which == 1) ? b_out_max_expo : c_out_max_expo;
            chk("out_data", {16'd0, od}, {16'd0, d});
            chk("out_max_expo", {27'd0, om}, {27'd0, me});
            if (stall > 0) chk("in_ready_in_done", {31'd0, a_in_ready}, 32'd0);
            set_ordy(which, 1'b1);
            @(posedge clk); #1;
            set_ordy(which, 1'b0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p;
        rst_n = 1'b0; clear = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = 0; c_out_ready = 0;
        last_acc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("reset_out_data",  {16'd0, a_out_data},  32'd0);
        @(posedge clk); #1;

        // 1+2+3+4 back-to-back
        send(0, 16'h3C00, 0); send(0, 16'h4000, 0);
        send(0, 16'h4200, 0); send(0, 16'h4400, 0);
        wait_out(0, 10, 16'h4900, 5'd17, 0);

        // Same vector with gaps and a 5-cycle output stall
        send(0, 16'h3C00, 2); send(0, 16'h4000, 1);
        send(0, 16'h4200, 3); send(0, 16'h4400, 0);
        wait_out(0, 10, 16'h4900, 5'd17, 5);

        // clear in WAIT after the second add issue
        send(0, 16'h3C00, 0); send(0, 16'h4000, 0);
        send(0, 16'h4200, 0); send(0, 16'h4400, 0);
        p = 0;
        for (int i = 0; i < 40 && p < 2; i++) begin
            @(negedge clk);
            if (a_add_valid) p++;
        end
        chk("clear_issue_seen", p, 2);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("clear_out_valid", {31'd0, a_out_valid}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(0, 16'h3C00, 0);
        wait_out(0, 10, 16'h4400, 5'd15, 0);

        // Reset mid-load after two words
        send(0, 16'h4400, 0); send(0, 16'h4400, 0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        chk("rst_add_valid", {31'd0, a_add_valid}, 32'd0);
        chk("rst_max_expo",  {27'd0, a_out_max_expo}, 32'd0);
        @(posedge clk); #1;
        send(0, 16'h3C00, 0); send(0, 16'h4000, 0);
        send(0, 16'h4200, 0); send(0, 16'h4400, 0);
        wait_out(0, 10, 16'h4900, 5'd17, 0);

        // Single-input instance: passthrough, no adds
        send(1, 16'hC500, 0);
        wait_out(1, 1, 16'hC500, 5'd17, 0);
        chk("b_no_add_pulse", b_pulses, 0);

        // ADD_LAT=1, three inputs: 1 + (-1) + 0.5
        send(2, 16'h3C00, 0); send(2, 16'hBC00, 0); send(2, 16'h3800, 0);
        wait_out(2, 5, 16'h3800, 5'd15, 0);
        chk("c_pulse_count", c_pulses, 2);
        chk("c_pulse_spacing", c_pcyc[1] - c_pcyc[0], 2);
        chk("c_first_issue", c_pcyc[0] - last_acc, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
